// File: rtl/bcd2bin_loader_if.sv
// Bundle of set-mode BCD fields, load controls and the published binary time/date.
interface bcd2bin_loader_if;
  logic        start;
  logic [7:0]  save_hour;
  logic [7:0]  save_min;
  logic [7:0]  save_sec;
  logic [15:0] save_year;
  logic [7:0]  save_mon;
  logic [7:0]  save_day;
  logic [4:0]  max_date;

  logic [4:0]  hour;
  logic [5:0]  min;
  logic [5:0]  sec;
  logic [13:0] year;
  logic [3:0]  month;
  logic [4:0]  day;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  err_field;

  // Requester side: drives BCD fields and start, observes the loaded values.
  modport master (
    output start, save_hour, save_min, save_sec, save_year, save_mon, save_day, max_date,
    input  hour, min, sec, year, month, day, busy, done, err, err_field
  );

  // Converter side.
  modport slave (
    input  start, save_hour, save_min, save_sec, save_year, save_mon, save_day, max_date,
    output hour, min, sec, year, month, day, busy, done, err, err_field
  );
endinterface

// File: rtl/bcd2bin_loader.sv
// Digit-serial BCD-to-binary converter feeding the watch/date counters.
// One shared x10 accumulator walks 14 digits (sec, min, hour, day, month, year),
// range-checks each field and publishes all fields atomically on success.
module bcd2bin_loader (
  input  logic               clk,
  input  logic               rst,
  bcd2bin_loader_if.slave    bus
);

  localparam int unsigned DIG_W  = 4;
  localparam int unsigned N_DIG  = 14;
  localparam int unsigned SNAP_W = DIG_W * N_DIG;
  localparam int unsigned ACC_W  = 14;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FLD_W  = 3;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned HOUR_W = 5;
  localparam int unsigned DAY_W  = 5;
  localparam int unsigned MON_W  = 4;
  localparam int unsigned YEAR_W = 14;

  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(N_DIG - 1);
  localparam logic [CNT_W-1:0] YEAR_DIG = CNT_W'(10);

  localparam logic [FLD_W-1:0] F_SEC  = FLD_W'(0);
  localparam logic [FLD_W-1:0] F_MIN  = FLD_W'(1);
  localparam logic [FLD_W-1:0] F_HOUR = FLD_W'(2);
  localparam logic [FLD_W-1:0] F_DAY  = FLD_W'(3);
  localparam logic [FLD_W-1:0] F_MON  = FLD_W'(4);
  localparam logic [FLD_W-1:0] F_YEAR = FLD_W'(5);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_FINISH} state_t;

  state_t              state_q, state_d;

  logic [SNAP_W-1:0]   snap_q;
  logic [DAY_W-1:0]    maxd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ACC_W-1:0]    acc_q;
  logic                fld_bad_q;
  logic                err_seen_q;

  logic [SEC_W-1:0]    stg_sec_q;
  logic [SEC_W-1:0]    stg_min_q;
  logic [HOUR_W-1:0]   stg_hour_q;
  logic [DAY_W-1:0]    stg_day_q;
  logic [MON_W-1:0]    stg_mon_q;

  logic [HOUR_W-1:0]   hour_q;
  logic [SEC_W-1:0]    min_q;
  logic [SEC_W-1:0]    sec_q;
  logic [YEAR_W-1:0]   year_q;
  logic [MON_W-1:0]    month_q;
  logic [DAY_W-1:0]    day_q;
  logic                busy_q;
  logic                done_q;
  logic                err_pulse_q;
  logic [FLD_W-1:0]    err_field_q;

  logic                start_ok_c;
  logic                conv_c;
  logic [DIG_W-1:0]    digit_c;
  logic                first_c;
  logic                last_c;
  logic [FLD_W-1:0]    fld_c;
  logic [ACC_W-1:0]    val_c;
  logic                fld_bad_c;
  logic                range_bad_c;
  logic                fail_c;
  logic                err_all_c;
  logic                fin_c;
  logic                busy_d;
  logic                done_d;
  logic                err_pulse_d;

  // FINISH is not busy, so a new request is taken there as well as in IDLE.
  assign start_ok_c = bus.start && (state_q != S_CONV);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_CONV;
      S_CONV:   if (cnt_q == LAST_DIG) state_d = S_FINISH;
      S_FINISH: state_d = bus.start ? S_CONV : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Digit decode, accumulator step, field checks and next values of the status outputs.
  always_comb begin
    conv_c      = (state_q == S_CONV);
    digit_c     = snap_q[SNAP_W-1 -: DIG_W];
    first_c     = (cnt_q <= YEAR_DIG) && !cnt_q[0];
    last_c      = ((cnt_q < YEAR_DIG) && cnt_q[0]) || (cnt_q == LAST_DIG);
    fld_c       = (cnt_q >= YEAR_DIG) ? F_YEAR : FLD_W'(cnt_q >> 1);
    val_c       = first_c ? ACC_W'(digit_c)
                          : ACC_W'(acc_q * ACC_W'(10)) + ACC_W'(digit_c);
    fld_bad_c   = (!first_c && fld_bad_q) || (digit_c > DIG_W'(9));
    range_bad_c = 1'b0;
    // Checked on the full decimal value so e.g. hour 33 cannot alias into range.
    case (fld_c)
      F_SEC, F_MIN: range_bad_c = (val_c > ACC_W'(59));
      F_HOUR:       range_bad_c = (val_c > ACC_W'(23));
      F_DAY:        range_bad_c = (val_c == '0) || (val_c > ACC_W'(maxd_q));
      F_MON:        range_bad_c = (val_c == '0) || (val_c > ACC_W'(12));
      default:      range_bad_c = 1'b0;
    endcase
    fail_c      = conv_c && last_c && (fld_bad_c || range_bad_c);
    err_all_c   = err_seen_q || fail_c;
    fin_c       = conv_c && (cnt_q == LAST_DIG);
    done_d      = fin_c && !err_all_c;
    err_pulse_d = fin_c && err_all_c;
    busy_d      = (state_d == S_CONV);
  end

  // Snapshot, digit datapath, staging and atomic publish of the outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_q      <= '0;
      maxd_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      fld_bad_q   <= 1'b0;
      err_seen_q  <= 1'b0;
      stg_sec_q   <= '0;
      stg_min_q   <= '0;
      stg_hour_q  <= '0;
      stg_day_q   <= '0;
      stg_mon_q   <= '0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      year_q      <= YEAR_W'(2000);
      month_q     <= MON_W'(1);
      day_q       <= DAY_W'(1);
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_field_q <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_pulse_q <= err_pulse_d;
      if (start_ok_c) begin
        snap_q      <= {bus.save_sec, bus.save_min, bus.save_hour,
                        bus.save_day, bus.save_mon, bus.save_year};
        maxd_q      <= bus.max_date;
        cnt_q       <= '0;
        acc_q       <= '0;
        fld_bad_q   <= 1'b0;
        err_seen_q  <= 1'b0;
        err_field_q <= '0;
        stg_sec_q   <= '0;
        stg_min_q   <= '0;
        stg_hour_q  <= '0;
        stg_day_q   <= '0;
        stg_mon_q   <= '0;
      end else if (conv_c) begin
        snap_q     <= {snap_q[SNAP_W-DIG_W-1:0], DIG_W'(0)};
        cnt_q      <= cnt_q + CNT_W'(1);
        acc_q      <= val_c;
        fld_bad_q  <= fld_bad_c;
        err_seen_q <= err_all_c;
        if (fail_c && !err_seen_q) err_field_q <= fld_c;
        if (last_c) begin
          case (fld_c)
            F_SEC:   stg_sec_q  <= SEC_W'(val_c);
            F_MIN:   stg_min_q  <= SEC_W'(val_c);
            F_HOUR:  stg_hour_q <= HOUR_W'(val_c);
            F_DAY:   stg_day_q  <= DAY_W'(val_c);
            F_MON:   stg_mon_q  <= MON_W'(val_c);
            default: ;
          endcase
        end
        // Year is the last field, so it goes straight from the accumulator.
        if (done_d) begin
          sec_q   <= stg_sec_q;
          min_q   <= stg_min_q;
          hour_q  <= stg_hour_q;
          day_q   <= stg_day_q;
          month_q <= stg_mon_q;
          year_q  <= YEAR_W'(val_c);
        end
      end
    end
  end

  assign bus.hour      = hour_q;
  assign bus.min       = min_q;
  assign bus.sec       = sec_q;
  assign bus.year      = year_q;
  assign bus.month     = month_q;
  assign bus.day       = day_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_pulse_q;
  assign bus.err_field = err_field_q;

endmodule

// File: tb/tb_bcd2bin_loader.sv
// Self-checking bench for bcd2bin_loader: directed table, multi-cycle corner
// sequences and randomized loads against a decimal reference model.
module tb_bcd2bin_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd2bin_loader_if bus();

  bcd2bin_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]  hour;
    logic [7:0]  min;
    logic [7:0]  sec;
    logic [15:0] year;
    logic [7:0]  mon;
    logic [7:0]  day;
    logic [4:0]  md;
  } in_t;

  typedef struct {
    in_t in;
    bit  ok;
    int  ef;
    int  h, mi, s, y, mo, d;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Values the DUT should currently be publishing.
  int p_hour, p_min, p_sec, p_year, p_mon, p_day;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".hour"},  32'(bus.hour),  32'(p_hour));
    chk({tag, ".min"},   32'(bus.min),   32'(p_min));
    chk({tag, ".sec"},   32'(bus.sec),   32'(p_sec));
    chk({tag, ".year"},  32'(bus.year),  32'(p_year));
    chk({tag, ".month"}, 32'(bus.month), 32'(p_mon));
    chk({tag, ".day"},   32'(bus.day),   32'(p_day));
  endtask

  task automatic pub_reset();
    p_hour = 0; p_min = 0; p_sec = 0; p_year = 2000; p_mon = 1; p_day = 1;
  endtask

  function automatic in_t mk(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                             input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                             input logic [4:0] md);
    in_t v;
    v.hour = h; v.min = mi; v.sec = s; v.year = y; v.mon = mo; v.day = d; v.md = md;
    return v;
  endfunction

  // Decimal value of an nd-digit BCD number; flags any nibble above 9.
  function automatic int bcd_val(input logic [15:0] b, input int nd, output bit bad);
    int v;
    v = 0;
    bad = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      int dg;
      dg = int'((b >> (4 * i)) & 16'hF);
      if (dg > 9) bad = 1'b1;
      v = v * 10 + dg;
    end
    return v;
  endfunction

  // Reference: decode every field, apply its legal range, first failure in sec..year order wins.
  task automatic model(input in_t v, output bit ok, output int ef,
                       output int h, output int mi, output int s,
                       output int y, output int mo, output int d);
    int val [6];
    bit bad [6];
    int lo  [6];
    int hi  [6];
    val[0] = bcd_val({8'h00, v.sec},  2, bad[0]);
    val[1] = bcd_val({8'h00, v.min},  2, bad[1]);
    val[2] = bcd_val({8'h00, v.hour}, 2, bad[2]);
    val[3] = bcd_val({8'h00, v.day},  2, bad[3]);
    val[4] = bcd_val({8'h00, v.mon},  2, bad[4]);
    val[5] = bcd_val(v.year,          4, bad[5]);
    lo = '{0, 0, 0, 1, 1, 0};
    hi = '{59, 59, 23, int'(v.md), 12, 9999};
    ok = 1'b1;
    ef = 0;
    for (int i = 0; i < 6; i++) begin
      if (bad[i] || val[i] < lo[i] || val[i] > hi[i]) begin
        if (ok) ef = i;
        ok = 1'b0;
      end
    end
    s = val[0]; mi = val[1]; h = val[2]; d = val[3]; mo = val[4]; y = val[5];
  endtask

  task automatic apply(input in_t v);
    bus.save_hour = v.hour;
    bus.save_min  = v.min;
    bus.save_sec  = v.sec;
    bus.save_year = v.year;
    bus.save_mon  = v.mon;
    bus.save_day  = v.day;
    bus.max_date  = v.md;
  endtask

  // Call at a negedge (cycle 0). Returns at the negedge of cycle 15.
  task automatic run_conv(input in_t v, output bit d, output bit e);
    bit win_bad;
    win_bad = 1'b0;
    apply(v);
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) win_bad = 1'b1;
    end
    chk("busy_window", 32'(win_bad), 32'd0);
    @(negedge clk);
    d = bus.done;
    e = bus.err;
    chk("busy_clear", 32'(bus.busy), 32'd0);
  endtask

  function automatic in_t rnd_in();
    logic [55:0] p;
    logic [7:0]  s, mi, h, d, mo;
    logic [15:0] y;
    in_t v;
    s  = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
    mi = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
    h  = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
    d  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 9))};
    mo = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
    y  = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
          4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    p = {s, mi, h, d, mo, y};
    if ($urandom_range(0, 5) == 0) p[4 * $urandom_range(0, 13) +: 4] = 4'($urandom_range(10, 15));
    {s, mi, h, d, mo, y} = p;
    v = mk(h, mi, s, y, mo, d, 5'($urandom_range(28, 31)));
    return v;
  endfunction

  initial begin
    vec_t tbl [11];
    bit   gd, ge, ok, extra;
    int   ef, h, mi, s, y, mo, d;
    in_t  v;

    tbl[0]  = '{mk(8'h23, 8'h59, 8'h58, 16'h2024, 8'h02, 8'h29, 5'd29), 1'b1, 0, 23, 59, 58, 2024, 2, 29};
    tbl[1]  = '{mk(8'h23, 8'h59, 8'h58, 16'h2024, 8'h02, 8'h30, 5'd29), 1'b0, 3, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{mk(8'h24, 8'h59, 8'h58, 16'h2024, 8'h02, 8'h29, 5'd29), 1'b0, 2, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{mk(8'h10, 8'h75, 8'h5A, 16'h2024, 8'h02, 8'h29, 5'd29), 1'b0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{mk(8'h10, 8'h20, 8'h30, 16'h2024, 8'h00, 8'h29, 5'd29), 1'b0, 4, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{mk(8'h10, 8'h20, 8'h30, 16'h2024, 8'h13, 8'h15, 5'd31), 1'b0, 4, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{mk(8'h10, 8'h20, 8'h30, 16'h20A4, 8'h05, 8'h15, 5'd31), 1'b0, 5, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{mk(8'h00, 8'h00, 8'h00, 16'h0000, 8'h12, 8'h31, 5'd31), 1'b1, 0, 0, 0, 0, 0, 12, 31};
    tbl[8]  = '{mk(8'h09, 8'h07, 8'h05, 16'h9999, 8'h01, 8'h01, 5'd31), 1'b1, 0, 9, 7, 5, 9999, 1, 1};
    tbl[9]  = '{mk(8'h09, 8'h07, 8'h05, 16'h1999, 8'h01, 8'h00, 5'd31), 1'b0, 3, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{mk(8'h12, 8'h30, 8'h45, 16'h1999, 8'h11, 8'h30, 5'd30), 1'b1, 0, 12, 30, 45, 1999, 11, 30};

    bus.start = 1'b0;
    apply(mk(8'h0, 8'h0, 8'h0, 16'h0, 8'h0, 8'h0, 5'd0));
    pub_reset();

    // Reset values.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk_outs("reset");
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.err", 32'(bus.err), 32'd0);
    chk("reset.err_field", 32'(bus.err_field), 32'd0);

    // Directed table.
    foreach (tbl[i]) begin
      run_conv(tbl[i].in, gd, ge);
      chk($sformatf("tbl%0d.done", i), 32'(gd), 32'(tbl[i].ok));
      chk($sformatf("tbl%0d.err", i), 32'(ge), 32'(!tbl[i].ok));
      chk($sformatf("tbl%0d.err_field", i), 32'(bus.err_field), tbl[i].ok ? 32'd0 : 32'(tbl[i].ef));
      if (tbl[i].ok) begin
        p_hour = tbl[i].h; p_min = tbl[i].mi; p_sec = tbl[i].s;
        p_year = tbl[i].y; p_mon = tbl[i].mo; p_day = tbl[i].d;
      end
      chk_outs($sformatf("tbl%0d", i));
    end

    // Busy/snapshot: late save_min change and a second start while busy are ignored.
    extra = 1'b0;
    apply(mk(8'h10, 8'h42, 8'h33, 16'h2031, 8'h07, 8'h04, 5'd31));
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 3) bus.save_min = 8'h11;
      if (k == 5) bus.start = 1'b1;
      if (k == 6) bus.start = 1'b0;
      if (bus.done !== 1'b0 || bus.err !== 1'b0) extra = 1'b1;
    end
    @(negedge clk);
    chk("snap.early_pulse", 32'(extra), 32'd0);
    chk("snap.done15", 32'(bus.done), 32'd1);
    p_hour = 10; p_min = 42; p_sec = 33; p_year = 2031; p_mon = 7; p_day = 4;
    chk_outs("snap");
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("snap.done_one_cycle", 32'(bus.done), 32'd0);
    chk("snap.busy16", 32'(bus.busy), 32'd1);
    extra = 1'b0;
    for (int k = 17; k <= 29; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.err !== 1'b0) extra = 1'b1;
    end
    @(negedge clk);
    chk("b2b.early_pulse", 32'(extra), 32'd0);
    chk("b2b.done30", 32'(bus.done), 32'd1);
    p_min = 11;
    chk_outs("b2b");

    // Reset mid-conversion.
    v = mk(8'h07, 8'h08, 8'h09, 16'h2100, 8'h03, 8'h15, 5'd31);
    apply(v);
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    extra = 1'b0;
    for (int k = 9; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0) extra = 1'b1;
    end
    chk("midrst.quiet", 32'(extra), 32'd0);
    pub_reset();
    chk_outs("midrst");
    chk("midrst.err_field", 32'(bus.err_field), 32'd0);
    run_conv(v, gd, ge);
    chk("midrst.restart_done", 32'(gd), 32'd1);
    p_hour = 7; p_min = 8; p_sec = 9; p_year = 2100; p_mon = 3; p_day = 15;
    chk_outs("midrst.restart");

    // Randomized loads against the reference model.
    for (int n = 0; n < 300; n++) begin
      v = rnd_in();
      model(v, ok, ef, h, mi, s, y, mo, d);
      run_conv(v, gd, ge);
      chk($sformatf("rnd%0d.done", n), 32'(gd), 32'(ok));
      chk($sformatf("rnd%0d.err", n), 32'(ge), 32'(!ok));
      chk($sformatf("rnd%0d.err_field", n), 32'(bus.err_field), ok ? 32'd0 : 32'(ef));
      if (ok) begin
        p_hour = h; p_min = mi; p_sec = s; p_year = y; p_mon = mo; p_day = d;
      end
      chk_outs($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
